// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states, width defaults and flag bundle shared by the alu_exec_seq slice
package alu_pkg;
  localparam int DEF_RWIDTH = 6;
  localparam int DEF_DWIDTH = 32;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
    OP_SRA, OP_SLT, OP_SLTU, OP_PASSB, OP_MUL, OP_ILL13, OP_ILL14, OP_ILL15
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_MUL, S_WB} state_e;
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/alu_exec_seq_if.sv
// alu_exec_seq_if: instruction handshake, regfile ports and status outputs of alu_exec_seq
interface alu_exec_seq_if #(
  parameter int RWIDTH = alu_pkg::DEF_RWIDTH,
  parameter int DWIDTH = alu_pkg::DEF_DWIDTH
);
  logic in_valid, in_ready, in_use_imm, we, done, err, flag_z, flag_n, flag_c, flag_v;
  logic [3:0] in_op;
  logic [RWIDTH-1:0] in_rs1, in_rs2, in_rd, ra1, ra2, wa;
  logic [DWIDTH-1:0] in_imm, rd1, rd2, wd, result;
  modport slave (
    input in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm, rd1, rd2,
    output in_ready, ra1, ra2, wa, wd, we, done, err, result, flag_z, flag_n, flag_c, flag_v
  );
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm, rd1, rd2,
    input in_ready, ra1, ra2, wa, wd, we, done, err, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_core_32bit.sv
// alu_core_32bit: combinational 32-bit ALU; flags bad for opcodes it does not implement (MUL and 13-15)
module alu_core_32bit
  import alu_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output flags_t      f,
  output logic        bad
);
  logic [32:0] s, d;
  assign s = {1'b0, a} + {1'b0, b};
  assign d = {1'b0, a} - {1'b0, b};
  always_comb begin
    y = '0;
    f = '0;
    bad = 1'b0;
    case (op)
      OP_ADD: begin
        y = s[31:0];
        f.c = s[32];
        f.v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      OP_SUB: begin
        y = d[31:0];
        f.c = ~d[32];
        f.v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_SLL:   y = a << b[4:0];
      OP_SRL:   y = a >> b[4:0];
      OP_SRA:   y = $signed(a) >>> b[4:0];
      OP_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  y = {31'd0, a < b};
      OP_PASSB: y = b;
      default:  bad = 1'b1;
    endcase
    f.z = y == '0;
    f.n = y[31];
  end
endmodule

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: regfile execute/writeback sequencer; define ALU_MUL_EN to enable opcode 12 (iterative MUL)
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int RWIDTH = DEF_RWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input logic clk,
  input logic rst,
  alu_exec_seq_if.slave bus
);
  state_e state;
  op_e op;
  logic [RWIDTH-1:0] rd, ra1, ra2, wa;
  logic use_imm, bad, ill, fin, we, done, err;
  logic [DWIDTH-1:0] imm, b, y, ny, wd, result;
  flags_t f, nf, flg;
  assign b = use_imm ? imm : bus.rd2;
  alu_core_32bit u_core (.op(op), .a(bus.rd1), .b(b), .y(y), .f(f), .bad(bad));
`ifdef ALU_MUL_EN
  logic [DWIDTH-1:0] mc, mp, acc, acc_n;
  logic [4:0] cnt;
  assign acc_n = acc + (mp[0] ? mc : '0);
  assign ill = bad && op != OP_MUL;
  assign fin = state == S_MUL ? cnt == 5'd31 : op != OP_MUL;
  assign ny = state == S_MUL ? acc_n : y;
  assign nf = state == S_MUL ? flags_t'{z: acc_n == '0, n: acc_n[DWIDTH-1], c: 1'b0, v: 1'b0} : f;
  always_ff @(posedge clk)
    if (!rst) begin
      mc <= '0;
      mp <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == S_EX) begin
      mc <= bus.rd1;
      mp <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == S_MUL) begin
      mc <= mc << 1;
      mp <= mp >> 1;
      acc <= acc_n;
      cnt <= cnt + 5'd1;
    end
`else
  assign ill = bad;
  assign fin = 1'b1;
  assign ny = y;
  assign nf = f;
`endif
  // ra1/ra2 load at accept and hold through WB, so the regfile keeps re-reading the same operands
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      op <= OP_ADD;
      rd <= '0;
      use_imm <= 1'b0;
      imm <= '0;
      ra1 <= '0;
      ra2 <= '0;
      wa <= '0;
      wd <= '0;
      we <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      result <= '0;
      flg <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          state <= S_RD;
          op <= op_e'(bus.in_op);
          rd <= bus.in_rd;
          use_imm <= bus.in_use_imm;
          imm <= bus.in_imm;
          ra1 <= bus.in_rs1;
          ra2 <= bus.in_rs2;
        end
        S_RD: state <= S_EX;
        S_EX, S_MUL: if (fin) begin
          state <= S_WB;
          wa <= rd;
          wd <= ill ? result : ny;
          we <= !ill && rd != '0;
          done <= 1'b1;
          err <= ill;
          if (!ill) begin
            result <= ny;
            flg <= nf;
          end
        end else state <= S_MUL;
        default: begin
          state <= S_IDLE;
          we <= 1'b0;
          done <= 1'b0;
          err <= 1'b0;
        end
      endcase
    end
  end
  assign bus.in_ready = state == S_IDLE;
  assign bus.ra1 = ra1;
  assign bus.ra2 = ra2;
  assign bus.wa = wa;
  assign bus.wd = wd;
  assign bus.we = we;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.result = result;
  assign {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = flg;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: vector table, corner sequences and random ops against a reference model, with a regfile model
module tb_alu_exec_seq;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0, n_err = 0;
  logic [31:0] held_y = '0;
  logic [3:0] held_f = '0;
  always #5 clk = ~clk;

  alu_exec_seq_if bus ();
  alu_exec_seq dut (.clk(clk), .rst(rst), .bus(bus));

  // regfile: registered read only when not writing; preload port used while the DUT idles
  logic [31:0] mem [64] = '{default: '0};
  logic pl_en = 1'b0;
  logic [5:0] pl_a;
  logic [31:0] pl_d;
  always @(posedge clk) begin
    if (bus.we) begin
      if (bus.wa != 0) mem[bus.wa] <= bus.wd;
    end else begin
      if (pl_en) mem[pl_a] <= pl_d;
      bus.rd1 <= mem[bus.ra1];
      bus.rd2 <= mem[bus.ra2];
    end
  end

  typedef struct packed {
    logic [3:0] op;
    logic [31:0] a, b;
    logic ui;
    logic [31:0] imm;
    logic [5:0] rd;
    logic [31:0] y;
    logic [3:0] f;
    logic err;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_a = a;
    pl_d = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_we", bus.we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_wa", bus.wa, 0);
    chk("rst_wd", bus.wd, 0);
    chk("rst_ra1", bus.ra1, 0);
    chk("rst_ra2", bus.ra2, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", bus.in_ready, 1);
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] rs1, rs2, rd, input logic ui, input logic [31:0] imm);
    bus.in_op = op;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_rd = rd;
    bus.in_use_imm = ui;
    bus.in_imm = imm;
    bus.in_valid = 1'b1;
  endtask

  // called at a negedge; walks the whole instruction and returns at the negedge after WB
  task automatic do_instr(input logic [3:0] op, input logic [5:0] rs1, rs2, rd, input logic ui,
                          input logic [31:0] imm, input logic [31:0] ey, input logic [3:0] ef, input logic eerr);
    int lat = 3;
    logic ewe;
`ifdef ALU_MUL_EN
    if (op == 4'd12) lat = 35;
`endif
    ewe = !eerr && rd != 0;
    wait_ready();
    drive(op, rs1, rs2, rd, ui, imm);
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (k == 2) begin
        chk("ex_ra1", bus.ra1, rs1);
        chk("ex_ra2", bus.ra2, rs2);
      end
      if (k < lat) begin
        chk("busy_ready", bus.in_ready, 0);
        chk("busy_we", bus.we, 0);
        chk("busy_done", bus.done, 0);
      end else if (k == lat) begin
        chk("wb_we", bus.we, ewe);
        chk("wb_done", bus.done, 1);
        chk("wb_err", bus.err, eerr);
        chk("wb_ready", bus.in_ready, 0);
        if (ewe) begin
          chk("wb_wa", bus.wa, rd);
          chk("wb_wd", bus.wd, ey);
        end
      end else begin
        chk("result", bus.result, ey);
        chk("flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, ef);
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_we", bus.we, 0);
        chk("idle_done", bus.done, 0);
      end
    end
  endtask

  // reference ALU in plain 64-bit arithmetic; f = {z, n, c, v}
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] y, output logic [3:0] f, output logic ill);
    longint unsigned ua = a, ub = b;
    longint sa = $signed(a), sb = $signed(b);
    longint r = 0;
    logic c = 1'b0, v = 1'b0;
    ill = 1'b0;
    y = '0;
    case (op)
      0: begin
        r = sa + sb;
        y = 32'(ua + ub);
        c = (ua + ub) > 64'hFFFF_FFFF;
        v = r > 64'sd2147483647 || r < -64'sd2147483648;
      end
      1: begin
        r = sa - sb;
        y = 32'(ua - ub);
        c = ua >= ub;
        v = r > 64'sd2147483647 || r < -64'sd2147483648;
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = ~(a | b);
      6: y = 32'(ua << b[4:0]);
      7: y = 32'(ua >> b[4:0]);
      8: y = 32'(sa >>> b[4:0]);
      9: y = {31'd0, sa < sb};
      10: y = {31'd0, ua < ub};
      11: y = b;
`ifdef ALU_MUL_EN
      12: y = 32'(ua * ub);
`endif
      default: ill = 1'b1;
    endcase
    f = {y == 0, y[31], c, v};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    return $urandom_range(0, 2) == 0 ? corner[$urandom_range(0, 3)] : $urandom();
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();

    tbl = '{
      '{4'd0,  32'd5,         32'd7,         1'b0, 32'd0,    6'd3,  32'd12,        4'b0000, 1'b0},
      '{4'd1,  32'd0,         32'd1,         1'b0, 32'd0,    6'd4,  32'hFFFF_FFFF, 4'b0100, 1'b0},
      '{4'd0,  32'h7FFF_FFFF, 32'd0,         1'b1, 32'd1,    6'd5,  32'h8000_0000, 4'b0101, 1'b0},
      '{4'd0,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,    6'd6,  32'h0,         4'b1010, 1'b0},
      '{4'd0,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,    6'd6,  32'h0,         4'b1011, 1'b0},
      '{4'd1,  32'd5,         32'd5,         1'b0, 32'd0,    6'd6,  32'h0,         4'b1010, 1'b0},
      '{4'd1,  32'h8000_0000, 32'd1,         1'b0, 32'd0,    6'd7,  32'h7FFF_FFFF, 4'b0011, 1'b0},
      '{4'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'd0,    6'd8,  32'h00F0_000F, 4'b0000, 1'b0},
      '{4'd3,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'd0,    6'd8,  32'hFFF0_0FFF, 4'b0100, 1'b0},
      '{4'd4,  32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'd0,    6'd8,  32'hFF00_0FF0, 4'b0100, 1'b0},
      '{4'd5,  32'd0,         32'd0,         1'b0, 32'd0,    6'd9,  32'hFFFF_FFFF, 4'b0100, 1'b0},
      '{4'd6,  32'd1,         32'h3F,        1'b0, 32'd0,    6'd9,  32'h8000_0000, 4'b0100, 1'b0},
      '{4'd7,  32'h8000_0000, 32'd4,         1'b0, 32'd0,    6'd9,  32'h0800_0000, 4'b0000, 1'b0},
      '{4'd8,  32'h8000_0000, 32'd4,         1'b0, 32'd0,    6'd9,  32'hF800_0000, 4'b0100, 1'b0},
      '{4'd9,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,    6'd9,  32'd1,         4'b0000, 1'b0},
      '{4'd10, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,    6'd9,  32'd0,         4'b1000, 1'b0},
      '{4'd11, 32'd0,         32'd0,         1'b1, 32'h1234, 6'd9,  32'h1234,      4'b0000, 1'b0},
      '{4'd0,  32'd5,         32'd7,         1'b0, 32'd0,    6'd0,  32'd12,        4'b0000, 1'b0},
      '{4'd14, 32'd1,         32'd2,         1'b0, 32'd0,    6'd9,  32'd0,         4'b0000, 1'b1},
      '{4'd15, 32'd1,         32'd2,         1'b0, 32'd0,    6'd9,  32'd0,         4'b0000, 1'b1}
    };
    foreach (tbl[i]) begin
      preload(1, tbl[i].a);
      preload(2, tbl[i].b);
      if (tbl[i].err) do_instr(tbl[i].op, 1, 2, tbl[i].rd, tbl[i].ui, tbl[i].imm, held_y, held_f, 1'b1);
      else begin
        do_instr(tbl[i].op, 1, 2, tbl[i].rd, tbl[i].ui, tbl[i].imm, tbl[i].y, tbl[i].f, 1'b0);
        held_y = tbl[i].y;
        held_f = tbl[i].f;
      end
    end
    chk("rd0_not_written", mem[0], 0);

    preload(1, 32'd3000);
    preload(2, 32'd70000);
`ifdef ALU_MUL_EN
    do_instr(12, 1, 2, 12, 0, 0, 32'h0C84_5880, 4'b0000, 1'b0);
    held_y = 32'h0C84_5880;
    held_f = 4'b0000;
`else
    do_instr(12, 1, 2, 12, 0, 0, held_y, held_f, 1'b1);
`endif

    // in_valid held high: accepts at cycles 0, 4, 8
    preload(1, 32'd10);
    preload(2, 32'd20);
    drive(0, 1, 2, 11, 0, 0);
    for (int k = 0; k < 12; k++) begin
      chk("stream_ready", bus.in_ready, k % 4 == 0);
      chk("stream_done", bus.done, k % 4 == 3);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("stream_mem", mem[11], 32'd30);

    // reset during EX drops the instruction
    preload(10, 32'hDEAD_BEEF);
    drive(0, 1, 2, 10, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset();
    repeat (4) begin
      chk("post_rst_we", bus.we, 0);
      chk("post_rst_done", bus.done, 0);
      @(negedge clk);
    end
    chk("post_rst_mem", mem[10], 32'hDEAD_BEEF);
    do_instr(0, 1, 2, 10, 0, 0, 32'd30, 4'b0000, 1'b0);
    held_y = 32'd30;
    held_f = 4'b0000;

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op, f;
      logic [5:0] s1, s2, d;
      logic [31:0] a, b, im, y;
      logic ui, ill;
      op = 4'($urandom_range(0, 15));
      s1 = 6'($urandom_range(0, 63));
      s2 = 6'($urandom_range(0, 63));
      d = 6'($urandom_range(0, 63));
      a = s1 == 0 ? 32'd0 : pick();
      b = s2 == 0 ? 32'd0 : (s2 == s1 ? a : pick());
      if (s1 != 0) preload(s1, a);
      if (s2 != 0 && s2 != s1) preload(s2, b);
      ui = 1'($urandom_range(0, 1));
      im = pick();
      ref_alu(op, a, ui ? im : b, y, f, ill);
      do_instr(op, s1, s2, d, ui, im, ill ? held_y : y, ill ? held_f : f, ill);
      if (!ill) begin
        held_y = y;
        held_f = f;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Execute/writeback sequencer sitting directly in front of the 32-bit register file. It accepts one ALU instruction at a time over a valid/ready handshake and drives the regfile read ports. It waits out the regfile's one-cycle registered read, computes the result, and issues the writeback. Because the regfile only updates rd1/rd2 on cycles with we=0, reads and writes are time-multiplexed by an FSM.

## Interface
- RWIDTH, 6: register address width (64 registers, r0 hardwired zero)
- DWIDTH, 32: datapath width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept (high only in IDLE)
- in_op  in  4  opcode
- in_rs1, in_rs2, in_rd  in  RWIDTH  source/destination registers
- in_use_imm  in  1  operand B = in_imm instead of rd2
- in_imm  in  DWIDTH  immediate
- ra1, ra2  out  RWIDTH  regfile read addresses
- rd1, rd2  in  DWIDTH  regfile read data (registered in regfile)
- wa  out  RWIDTH  regfile write address
- wd  out  DWIDTH  regfile write data
- we  out  1  regfile write enable
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse for an illegal opcode, coincident with done
- result  out  DWIDTH  last result, held
- flag_z, flag_n, flag_c, flag_v  out  1  zero/negative/carry/overflow of last op, held

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 PASSB, 12 MUL (macro-gated), 13-15 illegal.
- Shift amount is B[4:0]. SLT/SLTU produce 32'h1 or 32'h0.
- C flag: carry-out for ADD; for SUB, 1 = no borrow. V flag: signed overflow, ADD/SUB only. C and V are 0 for all other ops. Z and N are taken from the 32-bit result.
- FSM states: IDLE, RD, EX, MUL, WB.
  - IDLE -> RD on in_valid && in_ready. All in_* fields are latched on that edge.
  - RD: ra1/ra2 driven from latched rs1/rs2, we=0. -> EX.
  - EX: rd1/rd2 are valid. Compute, then register result and flags. -> MUL if op=MUL and the macro is defined, else -> WB.
  - WB: wa=latched rd, wd=result, we=1 unless rd==0 or the op is illegal. Pulse done (and err if illegal). -> IDLE.
- ra1/ra2 stay stable from RD through WB, so the extra regfile read during EX is harmless.
- Illegal op: no write, err=1, result and flags unchanged.
- Reset values: in_ready=1 (once out of reset), we=0, wa=0, wd=0, ra1=ra2=0, done=0, err=0, result=0, all flags 0, state IDLE.
- Reset mid-operation: the in-flight instruction is dropped, no write is issued, and there is no done pulse.

## Timing
- The accept edge is cycle 0. The block is in RD during cycle 1, EX during cycle 2 and WB during cycle 3.
- The regfile is written at the end of cycle 3. in_ready returns in cycle 4.
- Throughput: one instruction per 4 cycles. No pipelining and no back-to-back accept.
- in_ready is a function of state only and does not depend on in_valid.
- we is high during WB only, and never in any other state.

## Configuration
- ALU_MUL_EN defined:
  - Opcode 12 is an unsigned shift-add multiply, with low 32 bits written.
  - MUL state runs exactly 32 iterations, giving accept-to-WB in cycle 35.
  - Z/N come from the product; C/V = 0.
- ALU_MUL_EN undefined: opcode 12 is illegal and takes the err path, with no MUL state and no multiplier logic.

## Structure
- Shared package alu_pkg holds:
  - the opcode enum (4-bit) and the FSM state enum;
  - RWIDTH/DWIDTH defaults;
  - the flag struct {z,n,c,v}.
- Sub-module alu_core_32bit: purely combinational (op, a, b) -> (result, flags), instantiated once. The iterative multiplier stays in alu_exec_seq.

## Test plan
- Preload r1=5, r2=7; ADD rd=3 -> we=1, wa=3, wd=12 in cycle 3; done pulse; flags 0000.
- r1=0, r2=1; SUB rd=4 -> wd=32'hFFFFFFFF, N=1, C=0, V=0. Then r1=32'h7FFFFFFF, ADD imm 1 -> wd=32'h80000000, V=1, N=1.
- ADD with rd=0 -> done pulses, we stays 0. Opcode 14 -> err=1 with done, no write, result unchanged.
- in_valid held high continuously -> accepts exactly every 4 cycles; in_ready low in cycles 1-3.
- Assert rst low during EX -> next cycle IDLE with all outputs at reset values, no we, no done; the following instruction completes normally.
- With ALU_MUL_EN: r1=3000, r2=70000 MUL -> wd=32'h0C845880 in cycle 35. Without the macro: same stimulus -> err in cycle 3.
